axis_s: RTL and testbench

AXI-Stream slave that receives length-framed packets from an upstream AXI-Stream master and hands the beats to local logic over a valid/ready port. A per-packet expected length is loaded through a config port; the block checks the incoming `s_axis_tlast` against that length and flags early or late `tlast`. On a late `tlast` it discards beats until the sender's real `tlast` so framing recovers. A small FIFO decouples the stream side from the local consumer.

---
 rtl/axis_pkg.sv | 14 +
 rtl/d0fifo.sv | 101 ++++++++++
 rtl/axis_s.sv | 126 ++++++++++++
 tb/tb_axis_s.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and helpers for the axis_s stream slave
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DISCARD = 2'd2
  } axis_s_state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len);
  endfunction

endpackage

// File: rtl/d0fifo.sv
// rtl/d0fifo.sv - parameterised synchronous FIFO with optional status flags
module d0fifo #(
  parameter int WIDTH    = 8,
  parameter int SIZE     = 4,
  parameter int FULL     = 1,
  parameter int EMPTY    = 1,
  parameter int VALID    = 1,
  parameter int PEEK     = 1,
  parameter int AL_FULL  = 0,
  parameter int AL_EMPTY = 0,
  parameter int ACK      = 0,
  parameter int FLUSH    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             valid
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] FULL_AT  = CW'((AL_FULL != 0) ? SIZE - 1 : SIZE);
  localparam logic [CW-1:0] EMPTY_AT = CW'((AL_EMPTY != 0) ? 1 : 0);
  localparam logic [AW-1:0] LAST_PTR = AW'(SIZE - 1);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] mem_d [SIZE];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             do_push, do_pop, flush_en;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    // without ACK a write into a full FIFO is allowed when a pop frees the slot
    do_push  = push && ((ACK != 0) ? !full_q : (!full_q || do_pop));
    flush_en = (FLUSH != 0) && flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (flush_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
    full_d = (cnt_d >= FULL_AT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  generate
    if (PEEK != 0) begin : g_peek
      assign pop_data = mem_q[rd_ptr_q];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q, rdata_d;
      always_comb begin
        rdata_d = rdata_q;
        if (do_pop) rdata_d = mem_q[rd_ptr_q];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
      end
      assign pop_data = rdata_q;
    end
  endgenerate

  assign full  = (FULL  != 0) ? full_q : 1'b0;
  assign empty = (EMPTY != 0) ? (cnt_q <= EMPTY_AT) : 1'b0;
  assign valid = (VALID != 0) ? (cnt_q != '0) : 1'b0;

endmodule

// File: rtl/axis_s.sv
// rtl/axis_s.sv - length-checked AXI-Stream slave with local buffered output port
module axis_s
  import axis_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 128,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [WIDTH-1:0]           data_out,
  output logic                       last_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  input  logic                       config_valid,
  input  logic [$clog2(MAX_LEN)-1:0] config_len,
  output logic                       busy,
  output logic                       err_early,
  output logic                       err_late
);

  localparam int LW = len_w(MAX_LEN);

  axis_s_state_t state_q, state_d;
  logic [LW-1:0] count_q, count_d;
  logic [LW-1:0] len_q, len_d;
  logic          err_early_q, err_early_d;
  logic          err_late_q, err_late_d;
  logic          hs, push, pop, mark;
  logic          full, empty, fifo_valid;
  logic [WIDTH:0] head;

  assign s_axis_tready = (state_q == RUN) ? ~full : (state_q == DISCARD);
  assign hs            = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    err_early_d = 1'b0;
    err_late_d  = 1'b0;
    push        = 1'b0;
    mark        = s_axis_tlast || (count_q == len_q);
    case (state_q)
      IDLE: begin
        if (config_valid && (config_len != '0)) begin
          len_d   = config_len;
          count_d = LW'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          push = 1'b1;
          if (s_axis_tlast) begin
            err_early_d = (count_q != len_q);
            state_d     = IDLE;
          end else if (count_q == len_q) begin
            err_late_d = 1'b1;
            state_d    = DISCARD;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      DISCARD: begin
        // drop until the sender's own tlast so the next packet starts aligned
        if (hs && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= LW'(1);
      len_q       <= '0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
    end
  end

  d0fifo #(
    .WIDTH    (WIDTH + 1),
    .SIZE     (DEPTH),
    .FULL     (1),
    .EMPTY    (1),
    .VALID    (1),
    .PEEK     (1),
    .AL_FULL  (0),
    .AL_EMPTY (0),
    .ACK      (0),
    .FLUSH    (0)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (push),
    .push_data ({mark, s_axis_tdata}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .valid     (fifo_valid)
  );

  assign pop       = fifo_valid && ready_in;
  assign valid_out = ~empty;
  assign data_out  = head[WIDTH-1:0];
  assign last_out  = head[WIDTH];
  assign busy      = (state_q != IDLE);
  assign err_early = err_early_q;
  assign err_late  = err_late_q;

endmodule

// File: tb/tb_axis_s.sv
// tb/tb_axis_s.sv - directed self-checking bench for axis_s
module tb_axis_s;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] data_out;
  logic        last_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic        config_valid = 1'b0;
  logic [6:0]  config_len = '0;
  logic        busy;
  logic        err_early;
  logic        err_late;

  int checks = 0;
  int failures = 0;
  int err_e_cnt = 0;
  int err_l_cnt = 0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  axis_s dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .data_out      (data_out),
    .last_out      (last_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .config_valid  (config_valid),
    .config_len    (config_len),
    .busy          (busy),
    .err_early     (err_early),
    .err_late      (err_late)
  );

  always @(negedge clk) begin
    if (valid_out && ready_in) got_q.push_back({last_out, data_out});
    if (err_early) err_e_cnt++;
    if (err_late) err_l_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [6:0] len);
    config_valid = 1'b1;
    config_len   = len;
    @(posedge clk); #1;
    config_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, output int waits);
    bit ok = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    waits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1;
        break;
      end
      waits++;
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic cmp_out(input string tag);
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_n"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_beat"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic cmp_err(input string tag, input int e, input int l);
    check({tag, "_err_early"}, err_e_cnt, e);
    check({tag, "_err_late"}, err_l_cnt, l);
    err_e_cnt = 0;
    err_l_cnt = 0;
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("rst_tready", s_axis_tready, 0);
    check("rst_valid", valid_out, 0);
    check("rst_last", last_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err_early", err_early, 0);
    check("rst_err_late", err_late, 0);
    check("rst_data", data_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean packet
    ready_in = 1'b1;
    cfg(7'd4);
    check("clean_busy_up", busy, 1);
    check("clean_tready_up", s_axis_tready, 1);
    send_beat(32'hA0, 1'b0, w);
    check("clean_lat_valid", valid_out, 1);
    check("clean_lat_data", data_out, 32'hA0);
    send_beat(32'hA1, 1'b0, w);
    send_beat(32'hA2, 1'b0, w);
    send_beat(32'hA3, 1'b1, w);
    check("clean_busy_down", busy, 0);
    check("clean_tready_down", s_axis_tready, 0);
    exp_q = '{33'h0_000000A0, 33'h0_000000A1, 33'h0_000000A2, 33'h1_000000A3};
    cmp_out("clean");
    cmp_err("clean", 0, 0);

    // early tlast
    cfg(7'd5);
    send_beat(32'hB0, 1'b0, w);
    send_beat(32'hB1, 1'b0, w);
    send_beat(32'hB2, 1'b1, w);
    check("early_busy", busy, 0);
    exp_q = '{33'h0_000000B0, 33'h0_000000B1, 33'h1_000000B2};
    cmp_out("early");
    cmp_err("early", 1, 0);

    // late tlast: beats past the length are discarded without stalling
    cfg(7'd3);
    for (int i = 0; i < 6; i++) begin
      send_beat(32'hC0 + i, (i == 5), w);
      check("late_no_stall", w, 0);
    end
    check("late_busy", busy, 0);
    exp_q = '{33'h0_000000C0, 33'h0_000000C1, 33'h1_000000C2};
    cmp_out("late");
    cmp_err("late", 0, 1);

    // backpressure
    ready_in = 1'b0;
    cfg(7'd8);
    for (int i = 0; i < 4; i++) begin
      send_beat(32'hD0 + i, 1'b0, w);
      check("bp_fill_no_stall", w, 0);
    end
    repeat (3) begin
      @(negedge clk);
      check("bp_tready_full", s_axis_tready, 0);
    end
    check("bp_head", data_out, 32'hD0);
    @(posedge clk); #1;
    ready_in = 1'b1;
    for (int i = 4; i < 8; i++) send_beat(32'hD0 + i, (i == 7), w);
    check("bp_busy", busy, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'hD0 + i});
    cmp_out("bp");
    cmp_err("bp", 0, 0);

    // zero length ignored
    cfg(7'd0);
    @(negedge clk);
    check("zero_busy", busy, 0);
    check("zero_tready", s_axis_tready, 0);

    // config during RUN ignored, including on the final handshake
    cfg(7'd2);
    config_valid = 1'b1;
    config_len   = 7'd5;
    send_beat(32'hE0, 1'b0, w);
    send_beat(32'hE1, 1'b1, w);
    config_valid = 1'b0;
    config_len   = '0;
    check("cfgrun_busy", busy, 0);
    exp_q = '{33'h0_000000E0, 33'h1_000000E1};
    cmp_out("cfgrun");
    cmp_err("cfgrun", 0, 0);

    // reset mid-packet
    ready_in = 1'b0;
    cfg(7'd6);
    send_beat(32'hF0, 1'b0, w);
    send_beat(32'hF1, 1'b0, w);
    check("mid_valid_pre", valid_out, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tready", s_axis_tready, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_last", last_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_in = 1'b1;
    cfg(7'd2);
    send_beat(32'h60, 1'b0, w);
    send_beat(32'h61, 1'b1, w);
    check("post_busy", busy, 0);
    exp_q = '{33'h0_00000060, 33'h1_00000061};
    cmp_out("post");
    cmp_err("post", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
